dsp48e2_simd: RTL and testbench

DSP48E2_SIMD -- requirements
Module: dsp48e2_simd

---
 rtl/dsp48e2_simd_pkg.sv | 56 +++++
 rtl/dsp48e2_simd_if.sv | 25 ++
 rtl/dsp48e2_simd_alu.sv | 69 ++++++
 rtl/dsp48e2_simd.sv | 174 +++++++++++++++++
 tb/tb_dsp48e2_simd.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp48e2_simd_pkg.sv
// Shared definitions for the SIMD DSP slice: opmode field codes, ALU function
// codes, lane split modes and lane widths.
package dsp48e2_simd_pkg;

  localparam int DATA_W        = 48;
  localparam int LANE_W_ONE48  = 48;
  localparam int LANE_W_TWO24  = 24;
  localparam int LANE_W_FOUR12 = 12;

  typedef enum logic [1:0] {
    LANES_ONE48,
    LANES_TWO24,
    LANES_FOUR12
  } lane_mode_e;

  localparam logic [1:0] X_ZERO = 2'b00;
  localparam logic [1:0] X_M    = 2'b01;
  localparam logic [1:0] X_P    = 2'b10;
  localparam logic [1:0] X_AB   = 2'b11;

  localparam logic [1:0] Y_ZERO = 2'b00;
  localparam logic [1:0] Y_M    = 2'b01;
  localparam logic [1:0] Y_ONES = 2'b10;
  localparam logic [1:0] Y_C    = 2'b11;

  localparam logic [2:0] Z_ZERO = 3'b000;
  localparam logic [2:0] Z_P    = 3'b010;
  localparam logic [2:0] Z_C    = 3'b011;

  localparam logic [1:0] W_ZERO = 2'b00;
  localparam logic [1:0] W_P    = 2'b01;
  localparam logic [1:0] W_RND  = 2'b10;
  localparam logic [1:0] W_C    = 2'b11;

  localparam logic [3:0] ALU_ZPLUS  = 4'b0000;
  localparam logic [3:0] ALU_NEGZ   = 4'b0001;
  localparam logic [3:0] ALU_NOTSUM = 4'b0010;
  localparam logic [3:0] ALU_ZMINUS = 4'b0011;
  localparam logic [3:0] ALU_XOR0   = 4'b0100;
  localparam logic [3:0] ALU_XNOR0  = 4'b0101;
  localparam logic [3:0] ALU_XNOR1  = 4'b0110;
  localparam logic [3:0] ALU_XOR1   = 4'b0111;
  localparam logic [3:0] ALU_AND    = 4'b1100;
  localparam logic [3:0] ALU_ANDN   = 4'b1101;
  localparam logic [3:0] ALU_NAND   = 4'b1110;
  localparam logic [3:0] ALU_NOTOR  = 4'b1111;

  function automatic int lane_width(lane_mode_e mode);
    case (mode)
      LANES_FOUR12: return LANE_W_FOUR12;
      LANES_TWO24:  return LANE_W_TWO24;
      default:      return LANE_W_ONE48;
    endcase
  endfunction

endpackage

// File: rtl/dsp48e2_simd_if.sv
// Operand/control bus of the SIMD DSP slice; the driver uses master, the
// slice uses slave.
interface dsp48e2_simd_if;
  import dsp48e2_simd_pkg::*;

  logic              ce;
  logic [3:0]        alumode;
  logic [8:0]        opmode;
  logic              carryin;
  logic [29:0]       a;
  logic [17:0]       b;
  logic [DATA_W-1:0] c;
  logic [DATA_W-1:0] p;
  logic [3:0]        carryout;

  modport master (
    output ce, alumode, opmode, carryin, a, b, c,
    input  p, carryout
  );

  modport slave (
    input  ce, alumode, opmode, carryin, a, b, c,
    output p, carryout
  );
endinterface

// File: rtl/dsp48e2_simd_alu.sv
// One ALU lane: three-input arithmetic against Z plus the two-input logic
// unit; carry is confined to the lane.
module dsp_alu_lane
  import dsp48e2_simd_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic [3:0]       alumode,
  input  logic [1:0]       ysel,
  input  logic             cin,
  input  logic [WIDTH-1:0] w,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  logic [WIDTH:0]   s_ext;
  logic [WIDTH:0]   z_ext;
  logic [WIDTH:0]   arith;
  logic [WIDTH-1:0] logic_res;
  logic             is_logic;

  // One guard bit above the lane is enough: it becomes the lane carry-out.
  always_comb begin
    s_ext = {1'b0, w} + {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    z_ext = {1'b0, z};
    arith = '0;
    case (alumode)
      ALU_ZPLUS:  arith = z_ext + s_ext;
      ALU_ZMINUS: arith = z_ext - s_ext;
      ALU_NEGZ:   arith = s_ext + ~z_ext;
      ALU_NOTSUM: arith = ~(z_ext + s_ext);
      default:    arith = '0;
    endcase
  end

  // With Y selecting all ones the logic unit flips to its OR-family dual.
  always_comb begin
    logic_res = '0;
    if (ysel == Y_ZERO) begin
      case (alumode)
        ALU_XOR0, ALU_XOR1:   logic_res = x ^ z;
        ALU_XNOR0, ALU_XNOR1: logic_res = ~(x ^ z);
        ALU_AND:              logic_res = x & z;
        ALU_ANDN:             logic_res = x & ~z;
        ALU_NAND:             logic_res = ~(x & z);
        ALU_NOTOR:            logic_res = ~x | z;
        default:              logic_res = '0;
      endcase
    end else if (ysel == Y_ONES) begin
      case (alumode)
        ALU_XOR0, ALU_XOR1:   logic_res = ~(x ^ z);
        ALU_XNOR0, ALU_XNOR1: logic_res = x ^ z;
        ALU_AND:              logic_res = x | z;
        ALU_ANDN:             logic_res = x | ~z;
        ALU_NAND:             logic_res = ~(x | z);
        ALU_NOTOR:            logic_res = ~x & z;
        default:              logic_res = '0;
      endcase
    end
  end

  assign is_logic = (alumode[3:2] != 2'b00);
  assign result   = is_logic ? logic_res : arith[WIDTH-1:0];
  assign cout     = is_logic ? 1'b0 : arith[WIDTH];

endmodule

// File: rtl/dsp48e2_simd.sv
// SIMD DSP slice: optional A/B/C/P pipeline registers, signed 27x18 multiplier,
// W/X/Y/Z operand muxes and 1, 2 or 4 independent ALU lanes.
module dsp48e2_simd
  import dsp48e2_simd_pkg::*;
#(
  parameter string USE_SIMD = "ONE48",
  parameter string USE_MULT = "NONE",
  parameter int    AREG     = 0,
  parameter int    BREG     = 0,
  parameter int    CREG     = 0,
  parameter int    PREG     = 0
) (
  input logic           clock,
  input logic           reset,
  dsp48e2_simd_if.slave bus
);

  localparam bit SIMD_OK = (USE_SIMD == "ONE48") || (USE_SIMD == "TWO24") ||
                           (USE_SIMD == "FOUR12");
  localparam bit MULT_OK = (USE_MULT == "NONE") || (USE_MULT == "MULTIPLY");
  localparam bit REGS_OK = (AREG == 0 || AREG == 1) && (BREG == 0 || BREG == 1) &&
                           (CREG == 0 || CREG == 1) && (PREG == 0 || PREG == 1);

  localparam lane_mode_e LANE_MODE = (USE_SIMD == "FOUR12") ? LANES_FOUR12 :
                                     (USE_SIMD == "TWO24")  ? LANES_TWO24  : LANES_ONE48;
  localparam int LANE_W  = lane_width(LANE_MODE);
  localparam int LANES   = DATA_W / LANE_W;
  localparam bit MULT_ON = (USE_MULT == "MULTIPLY") && (LANE_MODE == LANES_ONE48);

  if (!SIMD_OK) begin : g_bad_simd
    $fatal(1, "dsp48e2_simd: USE_SIMD must be ONE48, TWO24 or FOUR12");
  end
  if (!MULT_OK) begin : g_bad_mult
    $fatal(1, "dsp48e2_simd: USE_MULT must be NONE or MULTIPLY");
  end
  if (!REGS_OK) begin : g_bad_regs
    $fatal(1, "dsp48e2_simd: AREG/BREG/CREG/PREG must be 0 or 1");
  end

  logic [29:0]       a_d;
  logic [17:0]       b_d;
  logic [DATA_W-1:0] c_d;

  if (AREG == 1) begin : g_areg
    logic [29:0] a_q;
    always_ff @(posedge clock) begin
      if (reset)       a_q <= '0;
      else if (bus.ce) a_q <= bus.a;
    end
    assign a_d = a_q;
  end else begin : g_acomb
    assign a_d = bus.a;
  end

  if (BREG == 1) begin : g_breg
    logic [17:0] b_q;
    always_ff @(posedge clock) begin
      if (reset)       b_q <= '0;
      else if (bus.ce) b_q <= bus.b;
    end
    assign b_d = b_q;
  end else begin : g_bcomb
    assign b_d = bus.b;
  end

  if (CREG == 1) begin : g_creg
    logic [DATA_W-1:0] c_q;
    always_ff @(posedge clock) begin
      if (reset)       c_q <= '0;
      else if (bus.ce) c_q <= bus.c;
    end
    assign c_d = c_q;
  end else begin : g_ccomb
    assign c_d = bus.c;
  end

  logic signed [44:0] prod;
  logic [DATA_W-1:0]  m;
  logic [DATA_W-1:0]  ab;
  logic [DATA_W-1:0]  p_fb;

  assign prod = $signed(a_d[26:0]) * $signed(b_d);
  assign m    = MULT_ON ? {{3{prod[44]}}, prod} : '0;
  assign ab   = {a_d, b_d};

  logic [DATA_W-1:0] x_mux;
  logic [DATA_W-1:0] y_mux;
  logic [DATA_W-1:0] z_mux;
  logic [DATA_W-1:0] w_mux;

  // The multiplier only ever enters through X, so Y_M contributes nothing.
  always_comb begin
    x_mux = '0;
    y_mux = '0;
    z_mux = '0;
    w_mux = '0;
    case (bus.opmode[1:0])
      X_ZERO: x_mux = '0;
      X_M:    x_mux = m;
      X_P:    x_mux = p_fb;
      X_AB:   x_mux = ab;
    endcase
    case (bus.opmode[3:2])
      Y_ZERO: y_mux = '0;
      Y_M:    y_mux = '0;
      Y_ONES: y_mux = '1;
      Y_C:    y_mux = c_d;
    endcase
    case (bus.opmode[6:4])
      Z_ZERO:  z_mux = '0;
      Z_P:     z_mux = p_fb;
      Z_C:     z_mux = c_d;
      default: z_mux = '0;
    endcase
    case (bus.opmode[8:7])
      W_ZERO: w_mux = '0;
      W_P:    w_mux = p_fb;
      W_RND:  w_mux = '0;
      W_C:    w_mux = c_d;
    endcase
  end

  logic [DATA_W-1:0] alu_res;
  logic [LANES-1:0]  lane_co;
  logic [3:0]        co_d;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dsp_alu_lane #(.WIDTH(LANE_W)) u_lane (
      .alumode (bus.alumode),
      .ysel    (bus.opmode[3:2]),
      .cin     ((i == 0) ? bus.carryin : 1'b0),
      .w       (w_mux[i*LANE_W +: LANE_W]),
      .x       (x_mux[i*LANE_W +: LANE_W]),
      .y       (y_mux[i*LANE_W +: LANE_W]),
      .z       (z_mux[i*LANE_W +: LANE_W]),
      .result  (alu_res[i*LANE_W +: LANE_W]),
      .cout    (lane_co[i])
    );
  end

  // Lane carries land on the carryout bit at the top of each lane's 12-bit slot.
  if (LANE_MODE == LANES_FOUR12) begin : g_co4
    assign co_d = lane_co[3:0];
  end else if (LANE_MODE == LANES_TWO24) begin : g_co2
    assign co_d = {lane_co[1], 1'b0, lane_co[0], 1'b0};
  end else begin : g_co1
    assign co_d = {lane_co[0], 3'b000};
  end

  if (PREG == 1) begin : g_preg
    logic [DATA_W-1:0] p_q;
    logic [3:0]        co_q;
    always_ff @(posedge clock) begin
      if (reset) begin
        p_q  <= '0;
        co_q <= '0;
      end else if (bus.ce) begin
        p_q  <= alu_res;
        co_q <= co_d;
      end
    end
    assign bus.p        = p_q;
    assign bus.carryout = co_q;
    assign p_fb         = p_q;
  end else begin : g_pcomb
    assign bus.p        = alu_res;
    assign bus.carryout = co_d;
    assign p_fb         = '0;
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, clock, reset, bus.ce};

endmodule

// File: tb/tb_dsp48e2_simd.sv
// Self-checking bench: table of combinational vectors on three lane
// configurations, plus clocked sequences on two pipelined instances.
module tb_dsp48e2_simd;
  import dsp48e2_simd_pkg::*;

  typedef struct {
    int unsigned tgt;
    logic [95:0] name;
    logic [8:0]  opmode;
    logic [3:0]  alumode;
    logic        cin;
    logic [47:0] ab;
    logic [47:0] c;
    logic [47:0] exp_p;
    logic [3:0]  exp_co;
    bit          chk_co;
  } vec_t;

  typedef struct {
    int unsigned tgt;
    logic [95:0] name;
    logic [47:0] exp_p;
    logic [3:0]  exp_co;
    bit          chk_co;
  } exp_t;

  localparam int NVEC = 21;
  localparam int NSTREAM = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  vec_t vecs [NVEC];
  exp_t sb_q [$];

  always #5 clock = ~clock;

  dsp48e2_simd_if if_four ();
  dsp48e2_simd_if if_two ();
  dsp48e2_simd_if if_one ();
  dsp48e2_simd_if if_pipe ();
  dsp48e2_simd_if if_full ();

  dsp48e2_simd #(.USE_SIMD("FOUR12"), .USE_MULT("NONE")) u_four (
    .clock(clock), .reset(reset), .bus(if_four));
  dsp48e2_simd #(.USE_SIMD("TWO24"), .USE_MULT("MULTIPLY")) u_two (
    .clock(clock), .reset(reset), .bus(if_two));
  dsp48e2_simd #(.USE_SIMD("ONE48"), .USE_MULT("MULTIPLY")) u_one (
    .clock(clock), .reset(reset), .bus(if_one));
  dsp48e2_simd #(.USE_SIMD("ONE48"), .USE_MULT("NONE"), .PREG(1)) u_pipe (
    .clock(clock), .reset(reset), .bus(if_pipe));
  dsp48e2_simd #(.USE_SIMD("ONE48"), .USE_MULT("NONE"),
                 .AREG(1), .BREG(1), .CREG(1), .PREG(1)) u_full (
    .clock(clock), .reset(reset), .bus(if_full));

  function automatic vec_t mk(input int unsigned tgt, input logic [95:0] nm,
                              input logic [8:0] op, input logic [3:0] alu, input logic cin,
                              input logic [47:0] ab, input logic [47:0] c,
                              input logic [47:0] ep, input logic [3:0] eco, input bit chk);
    vec_t v;
    v.tgt = tgt; v.name = nm; v.opmode = op; v.alumode = alu; v.cin = cin;
    v.ab = ab; v.c = c; v.exp_p = ep; v.exp_co = eco; v.chk_co = chk;
    return v;
  endfunction

  task automatic compareOut(input logic [95:0] nm, input logic [47:0] ap, input logic [47:0] ep,
                            input logic [3:0] ac, input logic [3:0] ec, input bit chk);
    checks++;
    if (ap !== ep) begin
      errors++;
      $display("[TB] FAIL %0s p: got %h expected %h", nm, ap, ep);
    end
    if (chk) begin
      checks++;
      if (ac !== ec) begin
        errors++;
        $display("[TB] FAIL %0s carryout: got %b expected %b", nm, ac, ec);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    case (v.tgt)
      0: begin
        if_four.opmode = v.opmode; if_four.alumode = v.alumode; if_four.carryin = v.cin;
        if_four.a = v.ab[47:18]; if_four.b = v.ab[17:0]; if_four.c = v.c;
      end
      1: begin
        if_two.opmode = v.opmode; if_two.alumode = v.alumode; if_two.carryin = v.cin;
        if_two.a = v.ab[47:18]; if_two.b = v.ab[17:0]; if_two.c = v.c;
      end
      default: begin
        if_one.opmode = v.opmode; if_one.alumode = v.alumode; if_one.carryin = v.cin;
        if_one.a = v.ab[47:18]; if_one.b = v.ab[17:0]; if_one.c = v.c;
      end
    endcase
    e.tgt = v.tgt; e.name = v.name; e.exp_p = v.exp_p; e.exp_co = v.exp_co; e.chk_co = v.chk_co;
    sb_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [47:0] ap;
    logic [3:0]  ac;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb_q.pop_front();
      case (e.tgt)
        0:       begin ap = if_four.p; ac = if_four.carryout; end
        1:       begin ap = if_two.p;  ac = if_two.carryout;  end
        default: begin ap = if_one.p;  ac = if_one.carryout;  end
      endcase
      compareOut(e.name, ap, e.exp_p, ac, e.exp_co, e.chk_co);
    end
  endtask

  task automatic driveFull(input logic [47:0] ab, input logic [47:0] c);
    if_full.a = ab[47:18];
    if_full.b = ab[17:0];
    if_full.c = c;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [48:0] sum;
    logic [47:0] rab;
    logic [47:0] rc;
    exp_t        e;

    vecs[0]  = mk(0, "four_and", 9'b000110011, 4'b1100, 1'b0,
                  {12'h000, 12'hAAA, 12'h0FF, 12'hF0F}, {12'h000, 12'hFFF, 12'hFF0, 12'h0F0},
                  {12'h000, 12'hAAA, 12'h0F0, 12'h000}, 4'b0000, 1'b1);
    vecs[1]  = mk(0, "four_add", 9'b000110011, 4'b0000, 1'b0,
                  {12'h000, 12'h000, 12'h005, 12'hFFF}, {12'h000, 12'h000, 12'h003, 12'h001},
                  {12'h000, 12'h000, 12'h008, 12'h000}, 4'b0001, 1'b1);
    vecs[2]  = mk(0, "four_cin", 9'b000110011, 4'b0000, 1'b1,
                  {4{12'hFFF}}, {12'h001, 12'h001, 12'h000, 12'h000},
                  {12'h000, 12'h000, 12'hFFF, 12'h000}, 4'b1101, 1'b1);
    vecs[3]  = mk(0, "four_xnor_y1", 9'b000111011, 4'b0100, 1'b0,
                  {36'h0, 12'hF0F}, {36'h0, 12'h0FF},
                  {12'hFFF, 12'hFFF, 12'hFFF, 12'h00F}, 4'b0000, 1'b1);
    vecs[4]  = mk(0, "four_logy11", 9'b000111111, 4'b1100, 1'b0,
                  48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'h0, 4'b0000, 1'b1);
    vecs[5]  = mk(0, "four_add_y1", 9'b000111011, 4'b0000, 1'b0,
                  {36'h0, 12'h001}, {36'h0, 12'h001},
                  {12'hFFF, 12'hFFF, 12'hFFF, 12'h001}, 4'b0001, 1'b1);
    vecs[6]  = mk(0, "four_xor", 9'b000110011, 4'b0111, 1'b0,
                  {12'h123, 36'h0}, {12'h321, 36'h0}, {12'h202, 36'h0}, 4'b0000, 1'b1);
    vecs[7]  = mk(1, "two_add", 9'b000110011, 4'b0000, 1'b0,
                  {24'h000001, 24'hFFFFFF}, {24'h000002, 24'h000001},
                  {24'h000003, 24'h000000}, 4'b0010, 1'b1);
    vecs[8]  = mk(1, "two_carry_hi", 9'b000110011, 4'b0000, 1'b1,
                  {24'hFFFFFF, 24'h000000}, {24'h000001, 24'h000000},
                  {24'h000000, 24'h000001}, 4'b1000, 1'b1);
    vecs[9]  = mk(1, "two_mult_off", 9'b000000001, 4'b0000, 1'b0,
                  {30'd3, 18'h3FFFE}, 48'h0, 48'h0, 4'b0000, 1'b1);
    vecs[10] = mk(2, "one_sub_pos", 9'b000110011, 4'b0011, 1'b0,
                  48'd3, 48'd10, 48'd7, 4'b0000, 1'b0);
    vecs[11] = mk(2, "one_sub_neg", 9'b000110011, 4'b0011, 1'b0,
                  48'd10, 48'd3, 48'hFFFF_FFFF_FFF9, 4'b0000, 1'b0);
    vecs[12] = mk(2, "one_mult", 9'b000000001, 4'b0000, 1'b0,
                  {30'd3, 18'h3FFFE}, 48'h0, 48'hFFFF_FFFF_FFFA, 4'b0000, 1'b1);
    vecs[13] = mk(2, "one_carry", 9'b000110011, 4'b0000, 1'b0,
                  48'hFFFF_FFFF_FFFF, 48'd1, 48'h0, 4'b1000, 1'b1);
    vecs[14] = mk(2, "one_negz", 9'b000110011, 4'b0001, 1'b0,
                  48'd8, 48'd5, 48'd2, 4'b0000, 1'b0);
    vecs[15] = mk(2, "one_notsum", 9'b000110011, 4'b0010, 1'b0,
                  48'd1, 48'd1, 48'hFFFF_FFFF_FFFD, 4'b0000, 1'b0);
    vecs[16] = mk(2, "one_notx_or_z", 9'b000110011, 4'b1111, 1'b0,
                  48'hFFFF_FFFF_0000, 48'h0001_0000_0000, 48'h0001_0000_FFFF, 4'b0000, 1'b1);
    vecs[17] = mk(2, "one_x_or_nz", 9'b000111011, 4'b1101, 1'b0,
                  48'h0, 48'hFFFF_FFFF_FFF0, 48'h0000_0000_000F, 4'b0000, 1'b1);
    vecs[18] = mk(2, "one_pfb_zero", 9'b010100011, 4'b0000, 1'b0,
                  48'd5, 48'd99, 48'd5, 4'b0000, 1'b1);
    vecs[19] = mk(2, "one_nand", 9'b000110011, 4'b1110, 1'b0,
                  48'hFF00_FF00_FF00, 48'hF0F0_F0F0_F0F0, 48'h0FFF_0FFF_0FFF, 4'b0000, 1'b1);
    vecs[20] = mk(2, "one_wyz_c", 9'b110111111, 4'b0000, 1'b0,
                  48'd1, 48'd2, 48'd7, 4'b0000, 1'b1);

    if_four.ce = 1'b1; if_four.opmode = '0; if_four.alumode = '0; if_four.carryin = 1'b0;
    if_four.a = '0; if_four.b = '0; if_four.c = '0;
    if_two.ce = 1'b1; if_two.opmode = '0; if_two.alumode = '0; if_two.carryin = 1'b0;
    if_two.a = '0; if_two.b = '0; if_two.c = '0;
    if_one.ce = 1'b1; if_one.opmode = '0; if_one.alumode = '0; if_one.carryin = 1'b0;
    if_one.a = '0; if_one.b = '0; if_one.c = '0;
    if_pipe.ce = 1'b1; if_pipe.opmode = 9'b000110011; if_pipe.alumode = '0;
    if_pipe.carryin = 1'b0; if_pipe.a = '0; if_pipe.b = '0; if_pipe.c = '0;
    if_full.ce = 1'b1; if_full.opmode = 9'b000110011; if_full.alumode = '0;
    if_full.carryin = 1'b0; if_full.a = '0; if_full.b = '0; if_full.c = '0;

    $display("[TB] combinational vector table");
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput();
    end

    $display("[TB] PREG=1 sequence");
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    compareOut("pipe_reset", if_pipe.p, 48'h0, if_pipe.carryout, 4'b0000, 1'b1);
    applyStimulus(vecs[10]);
    #1;
    checkOutput();
    reset = 1'b0;
    driveFull(48'h0, 48'h0);
    if_pipe.a = '0; if_pipe.b = 18'd1; if_pipe.c = 48'd2;
    #1;
    compareOut("pipe_lat0", if_pipe.p, 48'h0, if_pipe.carryout, 4'b0000, 1'b1);
    @(negedge clock);
    compareOut("pipe_lat1", if_pipe.p, 48'd3, if_pipe.carryout, 4'b0000, 1'b1);
    if_pipe.opmode = 9'b000100011;
    if_pipe.b = 18'd4;
    @(negedge clock);
    compareOut("pipe_acc1", if_pipe.p, 48'd7, if_pipe.carryout, 4'b0000, 1'b1);
    @(negedge clock);
    compareOut("pipe_acc2", if_pipe.p, 48'd11, if_pipe.carryout, 4'b0000, 1'b1);
    if_pipe.opmode = 9'b000110011;
    if_pipe.a = '1; if_pipe.b = '1; if_pipe.c = 48'd2;
    @(negedge clock);
    compareOut("pipe_carry", if_pipe.p, 48'd1, if_pipe.carryout, 4'b1000, 1'b1);
    if_pipe.ce = 1'b0;
    if_pipe.a = '0; if_pipe.b = 18'd5; if_pipe.c = 48'd5;
    @(negedge clock);
    compareOut("pipe_hold", if_pipe.p, 48'd1, if_pipe.carryout, 4'b1000, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    compareOut("pipe_rst_ce0", if_pipe.p, 48'h0, if_pipe.carryout, 4'b0000, 1'b1);
    reset = 1'b0;

    $display("[TB] full-pipeline stream");
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    compareOut("full_reset", if_full.p, 48'h0, if_full.carryout, 4'b0000, 1'b1);
    reset = 1'b0;
    for (int k = 0; k < NSTREAM + 2; k++) begin
      @(negedge clock);
      if (k >= 2) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL full_stream: got empty queue expected an entry");
        end else begin
          e = sb_q.pop_front();
          compareOut(e.name, if_full.p, e.exp_p, if_full.carryout, e.exp_co, e.chk_co);
        end
      end
      if (k < NSTREAM) begin
        rab = {$urandom, $urandom_range(65535, 0)};
        rc  = {$urandom, $urandom_range(65535, 0)};
        driveFull(rab, rc);
        sum = {1'b0, rab} + {1'b0, rc};
        e.tgt = 3; e.name = "full_stream"; e.exp_p = sum[47:0];
        e.exp_co = {sum[48], 3'b000}; e.chk_co = 1'b1;
        sb_q.push_back(e);
      end
    end

    $display("[TB] reset in flight");
    @(negedge clock);
    driveFull(48'h100, 48'h23);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    compareOut("full_rst_mid", if_full.p, 48'h0, if_full.carryout, 4'b0000, 1'b1);
    driveFull(48'h40, 48'h2);
    @(negedge clock);
    compareOut("full_rst_lat1", if_full.p, 48'h0, if_full.carryout, 4'b0000, 1'b1);
    @(negedge clock);
    compareOut("full_rst_lat2", if_full.p, 48'h42, if_full.carryout, 4'b0000, 1'b1);

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
